lvds_word_align_ctrl: RTL and testbench

Word-alignment controller for the 7:1 LVDS receive path. It sits between the per-lane serial-to-parallel shifters and the video/pixel logic, in the parallel `clock` domain. It searches for the rotation at which the LVDS clock-lane word matches the expected framing pattern, then applies that rotation to all data lanes. It holds lock while monitoring for loss of alignment and re-searches on failure.

---
 rtl/lvds_word_align_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_lvds_word_align_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/lvds_word_align_ctrl.sv
// Word-alignment controller for the 7:1 LVDS receive path: sweeps the clock-lane rotation until the
// framing pattern locks, applies it to all data lanes. Define LVDS_ALIGN_STATS_EN to build the lock-loss counter.
module lvds_word_align_ctrl #(
    parameter int         LANES         = 4,
    parameter logic [6:0] PATTERN       = 7'b1100011,
    parameter int         SETTLE_CYCLES = 4,
    parameter int         MATCH_COUNT   = 16,
    parameter int         ERR_LIMIT     = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [6:0]           clk_word,
    input  logic [7*LANES-1:0]   data_in,
    input  logic                 realign,
    output logic [7*LANES-1:0]   data_out,
    output logic [6:0]           clk_out,
    output logic [2:0]           rotate,
    output logic                 locked,
    output logic                 sweep_wrap,
    output logic [15:0]          lock_loss_cnt
);

    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] MATCH_LAST  = 8'(MATCH_COUNT - 1);
    localparam logic [7:0] ERR_LAST    = 8'(ERR_LIMIT - 1);

    // Selects bits [r+6:r] of the 14-bit window {prev, cur}; r=0 yields cur.
    function automatic logic [6:0] rot7(input logic [6:0] prev_w, input logic [6:0] cur_w,
                                        input logic [2:0] r);
        logic [13:0] win;
        win = {prev_w, cur_w} >> r;
        return win[6:0];
    endfunction

    logic [6:0]         clk_prev_r;
    logic [7*LANES-1:0] data_prev_r;
    logic [6:0]         clk_out_r;
    logic [7*LANES-1:0] data_out_r;
    logic [6:0]         clk_rot_s;
    logic [7*LANES-1:0] data_rot_s;
    logic [2:0]         rotate_r;
    logic [2:0]         rot_next_s;
    logic               locked_r;
    logic               sweep_wrap_r;
    state_t             state_r;
    logic [7:0]         settle_cnt_r;
    logic [7:0]         match_cnt_r;
    logic [7:0]         err_cnt_r;
    logic               match_s;
    logic               loss_evt_s;

    // Rotate every lane by the shared rotation.
    always_comb begin
        data_rot_s = '0;
        clk_rot_s  = rot7(clk_prev_r, clk_word, rotate_r);
        for (int k = 0; k < LANES; k++) begin
            data_rot_s[7*k +: 7] = rot7(data_prev_r[7*k +: 7], data_in[7*k +: 7], rotate_r);
        end
    end

    // Match, next rotation and lock-loss event decode.
    always_comb begin
        match_s    = (clk_out_r == PATTERN);
        rot_next_s = (rotate_r == 3'd6) ? 3'd0 : rotate_r + 3'd1;
        if (!realign && (state_r == ST_LOCKED) && !match_s && (err_cnt_r == ERR_LAST)) begin
            loss_evt_s = 1'b1;
        end else begin
            loss_evt_s = 1'b0;
        end
    end

    // Previous-word history and registered rotated outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            clk_prev_r  <= 7'd0;
            data_prev_r <= '0;
            clk_out_r   <= 7'd0;
            data_out_r  <= '0;
        end else begin
            clk_prev_r  <= clk_word;
            data_prev_r <= data_in;
            clk_out_r   <= clk_rot_s;
            data_out_r  <= data_rot_s;
        end
    end

    // Search / lock FSM; realign overrides any same-cycle decision.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r      <= ST_SETTLE;
            rotate_r     <= 3'd0;
            locked_r     <= 1'b0;
            sweep_wrap_r <= 1'b0;
            settle_cnt_r <= 8'd0;
            match_cnt_r  <= 8'd0;
            err_cnt_r    <= 8'd0;
        end else begin
            sweep_wrap_r <= 1'b0;
            if (realign) begin
                state_r      <= ST_SETTLE;
                locked_r     <= 1'b0;
                settle_cnt_r <= 8'd0;
                match_cnt_r  <= 8'd0;
                err_cnt_r    <= 8'd0;
            end else begin
                case (state_r)
                    ST_SETTLE: begin
                        if (settle_cnt_r == SETTLE_LAST) begin
                            state_r      <= ST_CHECK;
                            settle_cnt_r <= 8'd0;
                            match_cnt_r  <= 8'd0;
                        end else begin
                            settle_cnt_r <= settle_cnt_r + 8'd1;
                        end
                    end
                    ST_CHECK: begin
                        if (match_s) begin
                            if (match_cnt_r == MATCH_LAST) begin
                                state_r     <= ST_LOCKED;
                                locked_r    <= 1'b1;
                                match_cnt_r <= 8'd0;
                                err_cnt_r   <= 8'd0;
                            end else begin
                                match_cnt_r <= match_cnt_r + 8'd1;
                            end
                        end else begin
                            rotate_r     <= rot_next_s;
                            sweep_wrap_r <= (rotate_r == 3'd6);
                            state_r      <= ST_SETTLE;
                            settle_cnt_r <= 8'd0;
                            match_cnt_r  <= 8'd0;
                        end
                    end
                    ST_LOCKED: begin
                        if (match_s) begin
                            err_cnt_r <= 8'd0;
                        end else if (loss_evt_s) begin
                            locked_r     <= 1'b0;
                            rotate_r     <= rot_next_s;
                            err_cnt_r    <= 8'd0;
                            state_r      <= ST_SETTLE;
                            settle_cnt_r <= 8'd0;
                        end else begin
                            err_cnt_r <= err_cnt_r + 8'd1;
                        end
                    end
                    default: begin
                        state_r      <= ST_SETTLE;
                        locked_r     <= 1'b0;
                        settle_cnt_r <= 8'd0;
                        match_cnt_r  <= 8'd0;
                        err_cnt_r    <= 8'd0;
                    end
                endcase
            end
        end
    end

`ifdef LVDS_ALIGN_STATS_EN
    logic [15:0] loss_cnt_r;

    // Saturating lock-loss event counter, cleared only by reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            loss_cnt_r <= 16'h0000;
        end else if (loss_evt_s && (loss_cnt_r != 16'hFFFF)) begin
            loss_cnt_r <= loss_cnt_r + 16'h0001;
        end else begin
            loss_cnt_r <= loss_cnt_r;
        end
    end

    assign lock_loss_cnt = loss_cnt_r;
`else
    assign lock_loss_cnt = 16'h0000;
`endif

    assign data_out   = data_out_r;
    assign clk_out    = clk_out_r;
    assign rotate     = rotate_r;
    assign locked     = locked_r;
    assign sweep_wrap = sweep_wrap_r;

endmodule

// File: tb/tb_lvds_word_align_ctrl.sv
// Directed bench for lvds_word_align_ctrl: lanes are generated from aligned words placed at true offset 3.
module tb_lvds_word_align_ctrl;

    localparam int         LANES = 4;
    localparam logic [6:0] PAT   = 7'b1100011;
`ifdef LVDS_ALIGN_STATS_EN
    localparam logic [15:0] LOSS1 = 16'd1;
`else
    localparam logic [15:0] LOSS1 = 16'd0;
`endif

    logic                 clock = 1'b0;
    logic                 reset_n;
    logic [6:0]           clk_word;
    logic [7*LANES-1:0]   data_in;
    logic                 realign;
    logic [7*LANES-1:0]   data_out;
    logic [6:0]           clk_out;
    logic [2:0]           rotate;
    logic                 locked;
    logic                 sweep_wrap;
    logic [15:0]          lock_loss_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cur_n, sampled_n, bad_lo, bad_hi, cyc, wraps;
    bit clk_zero, ever_locked;
    logic [7*LANES-1:0] exp_d;

    lvds_word_align_ctrl dut (
        .clock(clock), .reset_n(reset_n), .clk_word(clk_word), .data_in(data_in),
        .realign(realign), .data_out(data_out), .clk_out(clk_out), .rotate(rotate),
        .locked(locked), .sweep_wrap(sweep_wrap), .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] tdata(input int n, input int k);
        return 7'((n * 5 + k * 13 + 17) % 128);
    endfunction

    function automatic logic [6:0] tclk(input int n);
        if (clk_zero) return 7'h00;
        if (n >= bad_lo && n < bad_hi) return 7'h00;
        return PAT;
    endfunction

    // Raw shifter word n that makes bits [9:3] of {raw(n-1), raw(n)} equal aligned word n.
    function automatic logic [6:0] rawf(input logic [6:0] t_n, input logic [6:0] t_n1);
        return {t_n[3:0], t_n1[6:4]};
    endfunction

    task automatic drive();
        clk_word = rawf(tclk(cur_n), tclk(cur_n + 1));
        for (int k = 0; k < LANES; k++) begin
            data_in[7*k +: 7] = rawf(tdata(cur_n, k), tdata(cur_n + 1, k));
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        sampled_n = cur_n;
        cur_n++;
        drive();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_rotate"}, 32'(rotate), 32'd0);
        chk({tag, "_locked"}, 32'(locked), 32'd0);
        chk({tag, "_sweep"}, 32'(sweep_wrap), 32'd0);
        chk({tag, "_clk_out"}, 32'(clk_out), 32'd0);
        chk({tag, "_data_out"}, 32'(data_out), 32'd0);
        chk({tag, "_loss"}, 32'(lock_loss_cnt), 32'd0);
    endtask

    initial begin
        reset_n  = 1'b0;
        realign  = 1'b0;
        clk_zero = 1'b0;
        bad_lo   = -1000;
        bad_hi   = -1000;
        cur_n    = 0;
        drive();
        tick();
        tick();
        chk_reset_state("reset");
        reset_n = 1'b1;

        // Clean stream: sweep 0,1,2,3 then lock 20 cycles after entering rotation 3.
        for (int e = 1; e <= 35; e++) begin
            tick();
            if (e == 4)  chk("rot_e4", 32'(rotate), 32'd0);
            if (e == 5)  chk("rot_e5", 32'(rotate), 32'd1);
            if (e == 10) chk("rot_e10", 32'(rotate), 32'd2);
            if (e == 15) chk("rot_e15", 32'(rotate), 32'd3);
            if (e == 34) chk("unlocked_e34", 32'(locked), 32'd0);
        end
        chk("locked_e35", 32'(locked), 32'd1);
        chk("lock_rot", 32'(rotate), 32'd3);
        chk("lock_clk_out", 32'(clk_out), 32'(PAT));
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < LANES; k++) exp_d[7*k +: 7] = tdata(sampled_n, k);
            chk("data_out", 32'(data_out), 32'(exp_d));
            tick();
        end

        // Two bursts of 3 bad words: lock holds, so the error count clears in between.
        for (int b = 0; b < 2; b++) begin
            bad_lo = cur_n + 2;
            bad_hi = bad_lo + 3;
            for (int i = 0; i < 10; i++) begin
                tick();
                chk("hold_3err", 32'(locked), 32'd1);
            end
        end
        chk("hold_rot", 32'(rotate), 32'd3);

        // Four bad words drop lock and advance rotation; sweep wraps and re-locks at 3.
        bad_lo = cur_n + 2;
        bad_hi = bad_lo + 4;
        while (sampled_n < bad_lo + 3) tick();
        chk("pre_drop_locked", 32'(locked), 32'd1);
        tick();
        chk("drop_locked", 32'(locked), 32'd0);
        chk("drop_rot", 32'(rotate), 32'd4);
        chk("drop_loss", 32'(lock_loss_cnt), 32'(LOSS1));
        cyc   = 0;
        wraps = 0;
        while (!locked && cyc < 200) begin
            tick();
            cyc++;
            if (sweep_wrap) begin
                wraps++;
                chk("wrap_rot0", 32'(rotate), 32'd0);
            end
        end
        chk("relock_cycles", 32'(cyc), 32'd50);
        chk("relock_wraps", 32'(wraps), 32'd1);
        chk("relock_rot", 32'(rotate), 32'd3);

        // Realign on the same edge as the 4th error: rotation held, no loss counted.
        bad_lo = cur_n + 2;
        bad_hi = bad_lo + 4;
        while (sampled_n < bad_lo + 3) tick();
        realign = 1'b1;
        tick();
        realign = 1'b0;
        chk("realign_locked", 32'(locked), 32'd0);
        chk("realign_rot", 32'(rotate), 32'd3);
        chk("realign_loss", 32'(lock_loss_cnt), 32'(LOSS1));
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (e == 19) chk("realign_e19", 32'(locked), 32'd0);
        end
        chk("realign_e20", 32'(locked), 32'd1);
        chk("realign_rot_after", 32'(rotate), 32'd3);

        // No valid pattern: continuous sweep, one wrap pulse per 35 cycles, never locks.
        reset_n  = 1'b0;
        clk_zero = 1'b1;
        tick();
        chk("reset2_loss", 32'(lock_loss_cnt), 32'd0);
        reset_n     = 1'b1;
        wraps       = 0;
        ever_locked = 1'b0;
        for (int e = 1; e <= 75; e++) begin
            tick();
            if (sweep_wrap) wraps++;
            if (locked) ever_locked = 1'b1;
            if (e == 30) chk("sweep_rot6", 32'(rotate), 32'd6);
            if (e == 35) chk("sweep_wrap_hi", 32'(sweep_wrap), 32'd1);
            if (e == 35) chk("sweep_rot0", 32'(rotate), 32'd0);
            if (e == 36) chk("sweep_wrap_lo", 32'(sweep_wrap), 32'd0);
        end
        chk("sweep_wraps", 32'(wraps), 32'd2);
        chk("sweep_never_locked", 32'(ever_locked), 32'd0);

        // One-cycle reset during CHECK at rotation 5, then a clean search from 0.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int e = 1; e <= 29; e++) tick();
        chk("check_rot5", 32'(rotate), 32'd5);
        reset_n  = 1'b0;
        clk_zero = 1'b0;
        tick();
        chk_reset_state("midreset");
        reset_n = 1'b1;
        for (int e = 1; e <= 35; e++) begin
            tick();
            if (e == 5) chk("restart_rot1", 32'(rotate), 32'd1);
        end
        chk("restart_locked", 32'(locked), 32'd1);
        chk("restart_rot3", 32'(rotate), 32'd3);
        chk("restart_clk_out", 32'(clk_out), 32'(PAT));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
